seq_pattern_gen: RTL and testbench

Serial pattern transmitter: on a start pulse, emits a fixed PAT_W-bit pattern MSB-first, one bit per clock. The pattern repeats a programmable number of times, with an optional idle gap between frames. The default pattern 11010 produces the serial stream that the team's sequence-detector blocks consume, for stimulus and loopback self-test. It sits in front of any single-bit serial sink, paired with out_valid.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_piso.sv | 28 ++
 rtl/seq_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the sequence detectors
// that consume its stream.
package seq_pkg;

    // Default pattern length and pattern, shared with the detector side
    localparam int unsigned PAT_W_DEF   = 5;
    localparam logic [4:0]  PATTERN_DEF = 5'b11010;

    // Generator FSM states; 2'b11 is unreachable and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } seq_state_t;

endpackage

// File: rtl/seq_piso.sv
// Loadable parallel-in / serial-out shift register, MSB shifted out first.
module seq_piso #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q;

    // Load has priority over shift; shifting moves bits toward the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeat_cnt frames per
// burst with gap idle cycles between frames, all outputs registered.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned      PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int unsigned      REP_W   = 8,
    parameter int unsigned      GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      BW      = $clog2(PAT_W);
    localparam logic [BW-1:0]    BIT_TOP = BW'(PAT_W - 1);
    // The MSB goes straight to the out register when a frame starts, so the
    // shift register is loaded with the remaining bits already lined up.
    localparam logic [PAT_W-1:0] PAT_REST = PATTERN << 1;

    seq_state_t       state;
    logic [BW-1:0]    bit_cnt;
    logic [REP_W-1:0] rep_left;
    logic [GAP_W-1:0] gap_val;
    logic [GAP_W-1:0] gap_left;

    logic start_ok;
    logic frame_end;
    logic last_frame;
    logic piso_load;
    logic piso_shift;
    logic piso_msb;

    // Decode burst start, frame boundaries and shift register control
    always_comb begin
        start_ok   = (state == ST_IDLE) && start && !abort && (repeat_cnt != '0);
        frame_end  = (state == ST_SHIFT) && !abort && (bit_cnt == '0);
        last_frame = (rep_left == REP_W'(1));
        piso_load  = start_ok
                   || (frame_end && !last_frame && (gap_val == '0))
                   || ((state == ST_GAP) && !abort && (gap_left == GAP_W'(1)));
        piso_shift = (state == ST_SHIFT) && !abort && (bit_cnt != '0);
    end

    seq_piso #(
        .W (PAT_W)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (PAT_REST),
        .msb   (piso_msb)
    );

    // FSM, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rep_left  <= '0;
            gap_val   <= '0;
            gap_left  <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (start_ok) begin
                        rep_left  <= repeat_cnt;
                        gap_val   <= gap;
                        bit_cnt   <= BIT_TOP;
                        out       <= PATTERN[PAT_W-1];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (bit_cnt != '0) begin
                        out     <= piso_msb;
                        bit_cnt <= bit_cnt - BW'(1);
                    end else begin
                        rep_left <= rep_left - REP_W'(1);
                        if (last_frame) begin
                            state     <= ST_IDLE;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (gap_val == '0) begin
                            out     <= PATTERN[PAT_W-1];
                            bit_cnt <= BIT_TOP;
                        end else begin
                            state     <= ST_GAP;
                            gap_left  <= gap_val;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (gap_left == GAP_W'(1)) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= BIT_TOP;
                        out       <= PATTERN[PAT_W-1];
                        out_valid <= 1'b1;
                    end else begin
                        gap_left <= gap_left - GAP_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: expected per-cycle output records
// {out_valid, out, busy, done} are queued when a burst is requested and
// compared one per clock as the DUT produces them.
module tb_seq_pattern_gen;

    localparam logic [4:0] PAT = 5'b11010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] repeat_cnt;
    logic [3:0] gap;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    seq_pattern_gen #(
        .PAT_W   (5),
        .PATTERN (PAT),
        .REP_W   (8),
        .GAP_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [3:0] obs();
        return {out_valid, out, busy, done};
    endfunction

    // Queue the expected cycles of a burst; stop_bits!=0 truncates after that
    // many valid bits (abort), which suppresses gaps past that point and done.
    function automatic void push_burst(int unsigned rep, int unsigned g, int unsigned stop_bits);
        int unsigned n = 0;
        bit          stopped = 1'b0;
        logic [4:0]  p = PAT;
        for (int unsigned f = 0; f < rep; f++) begin
            for (int i = 4; i >= 0; i--) begin
                if (!stopped) begin
                    if (stop_bits != 0 && n == stop_bits) stopped = 1'b1;
                    else begin
                        exp_q.push_back({1'b1, p[i], 1'b1, 1'b0});
                        n++;
                    end
                end
            end
            if (!stopped && stop_bits != 0 && n == stop_bits) stopped = 1'b1;
            if (!stopped && f + 1 < rep)
                for (int unsigned j = 0; j < g; j++) exp_q.push_back(4'b0010);
        end
        if (!stopped) exp_q.push_back(4'b0001);
        for (int j = 0; j < 3; j++) exp_q.push_back(4'b0000);
    endfunction

    task automatic test_reset();
        logic [3:0] e;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_cnt = '0; gap = '0;
        repeat (2) @(posedge clk);
        #1;
        e = 4'b0000; checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b (valid,out,busy,done)", obs(), e);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected %b", obs(), e);
        end
    endtask

    task automatic test_single();
        logic [3:0] e;
        int k = 0;
        repeat_cnt = 8'd1; gap = 4'd0; start = 1'b1;
        push_burst(1, 0, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL single cycle %0d: got %b expected %b", k, obs(), e);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        int k = 0;
        repeat_cnt = 8'd3; gap = 4'd0; start = 1'b1;
        push_burst(3, 0, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", k, obs(), e);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_gap(input logic [7:0] rep, input logic [3:0] g);
        logic [3:0] e;
        int k = 0;
        repeat_cnt = rep; gap = g; start = 1'b1;
        push_burst(rep, g, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL gap rep=%0d gap=%0d cycle %0d: got %b expected %b", rep, g, k, obs(), e);
            end
            if (k == 1) begin
                start = 1'b0;
                // mid-burst changes must not matter
                repeat_cnt = 8'd9;
                gap = 4'd7;
            end
        end
    endtask

    task automatic test_zero_repeat();
        logic [3:0] e;
        int k = 0;
        repeat_cnt = 8'd0; gap = 4'd1; start = 1'b1;
        for (int j = 0; j < 4; j++) exp_q.push_back(4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL zero_repeat cycle %0d: got %b expected %b", k, obs(), e);
            end
            if (k == 2) start = 1'b0;
        end
    endtask

    task automatic test_idle_abort();
        logic [3:0] e;
        int k = 0;
        repeat_cnt = 8'd1; gap = 4'd0; start = 1'b1; abort = 1'b1;
        for (int j = 0; j < 3; j++) exp_q.push_back(4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL idle_abort cycle %0d: got %b expected %b", k, obs(), e);
            end
            if (k == 1) begin start = 1'b0; abort = 1'b0; end
        end
    endtask

    task automatic test_abort();
        logic [3:0] e;
        int k = 0;
        repeat_cnt = 8'd4; gap = 4'd0; start = 1'b1;
        push_burst(4, 0, 8);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL abort cycle %0d: got %b expected %b", k, obs(), e);
            end
            case (k)
                1: start = 1'b0;
                3: begin start = 1'b1; repeat_cnt = 8'd1; end
                4: start = 1'b0;
                8: abort = 1'b1;
                9: abort = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_max_repeat();
        logic [3:0] e;
        int k = 0;
        repeat_cnt = 8'd255; gap = 4'd0; start = 1'b1;
        push_burst(255, 0, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL max_repeat cycle %0d: got %b expected %b", k, obs(), e);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        int k = 0;
        repeat_cnt = 8'd1; gap = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = {1'b1, PAT[4], 1'b1, 1'b0}; checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL async_reset_bit1: got %b expected %b", obs(), e);
        end
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        e = 4'b0000; checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL async_reset_drop: got %b expected %b", obs(), e);
        end
        #5 rst_n = 1'b1;
        for (int j = 0; j < 4; j++) exp_q.push_back(4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; k++;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL async_reset_idle cycle %0d: got %b expected %b", k, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap(8'd2, 4'd2);
        test_gap(8'd3, 4'd1);
        test_zero_repeat();
        test_single();
        test_idle_abort();
        test_abort();
        test_max_repeat();
        test_async_reset();
        test_single();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
